// File: rtl/sender_buffer_n.sv
// sender_buffer_n: word FIFO with edge-triggered enqueue feeding a byte serializer
module sender_buffer_n #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [8*WORD_BYTES-1:0]      data,
  input  logic                         start,
  input  logic                         sender_ready,
  output logic [7:0]                   output_data,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         overflow
);
  localparam int W = 8 * WORD_BYTES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] word_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic start_q, rise, push, pop, last;
  function automatic logic [7:0] pick(input logic [W-1:0] w, input int k);
    logic [W-1:0] s;
    s = w >> (8 * (MSB_FIRST != 0 ? WORD_BYTES - 1 - k : k));
    return s[7:0];
  endfunction
  assign full = cnt == CW'(DEPTH);
  assign count = cnt;
  assign busy = state != IDLE || cnt != '0;
  // SEND pops straight after the last byte so back-to-back words have no bubble
  always_comb begin
    rise = start & ~start_q;
    push = rise & ~full;
    last = idx == IW'(WORD_BYTES - 1);
    pop = state == LOAD || (state == SEND && sender_ready && last && cnt != '0);
  end
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= data;
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= IDLE;
      start_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      idx <= '0;
      word_q <= '0;
      output_data <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      start_q <= start;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        word_q <= mem[rd_ptr];
        idx <= '0;
        output_data <= pick(mem[rd_ptr], 0);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
      if (rise && full) overflow <= 1'b1;
      case (state)
        IDLE: if (cnt != '0) state <= LOAD;
        LOAD: begin
          state <= SEND;
          valid <= 1'b1;
        end
        SEND: if (sender_ready) begin
          if (!last) begin
            idx <= idx + IW'(1);
            output_data <= pick(word_q, int'(idx) + 1);
          end else if (cnt == '0) begin
            state <= IDLE;
            valid <= 1'b0;
            idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sender_buffer_n.sv
// tb_sender_buffer_n: directed and randomized checks of sender_buffer_n against a byte-queue model
module tb_sender_buffer_n;
  logic CLK = 0, reset = 0, start = 0, sender_ready = 0;
  logic [31:0] data = 0;
  logic [7:0] od_m, od_l, od_1;
  logic v_m, v_l, v_1, f_m, f_l, f_1, b_m, b_l, b_1, o_m, o_l, o_1;
  logic [2:0] c_m, c_l, c_1;
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  sender_buffer_n dut (.CLK(CLK), .reset(reset), .data(data), .start(start), .sender_ready(sender_ready),
    .output_data(od_m), .valid(v_m), .full(f_m), .count(c_m), .busy(b_m), .overflow(o_m));
  sender_buffer_n #(.MSB_FIRST(0)) dut_l (.CLK(CLK), .reset(reset), .data(data), .start(start),
    .sender_ready(sender_ready), .output_data(od_l), .valid(v_l), .full(f_l), .count(c_l), .busy(b_l),
    .overflow(o_l));
  sender_buffer_n #(.WORD_BYTES(1)) dut_1 (.CLK(CLK), .reset(reset), .data(data[7:0]), .start(start),
    .sender_ready(sender_ready), .output_data(od_1), .valid(v_1), .full(f_1), .count(c_1), .busy(b_1),
    .overflow(o_1));
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [7:0] msb_byte(input logic [31:0] w, input int k);
    return 8'(w >> (8 * (3 - k)));
  endfunction
  function automatic logic [7:0] lsb_byte(input logic [31:0] w, input int k);
    return 8'(w >> (8 * k));
  endfunction
  task automatic test_reset;
    reset = 0; start = 0; sender_ready = 0; data = 32'hFFFF_FFFF;
    tick; tick;
    checks++;
    if ({od_m, v_m, f_m, c_m, b_m, o_m} !== '0) begin
      failures++; $display("FAIL reset_m: got %h expected 0", {od_m, v_m, f_m, c_m, b_m, o_m});
    end
    checks++;
    if ({od_l, v_l, f_l, c_l, b_l, o_l} !== '0) begin
      failures++; $display("FAIL reset_l: got %h expected 0", {od_l, v_l, f_l, c_l, b_l, o_l});
    end
    reset = 1; tick;
    checks++;
    if ({v_m, b_m, c_m} !== '0) begin
      failures++; $display("FAIL reset_idle: got %h expected 0", {v_m, b_m, c_m});
    end
  endtask
  task automatic test_basic;
    logic [31:0] w = 32'hA1B2C3D4;
    sender_ready = 1; data = w; start = 1;
    tick; start = 0;
    checks++;
    if (c_m !== 3'd1 || v_m !== 1'b0) begin
      failures++; $display("FAIL basic_count: got count=%0d valid=%b expected 1/0", c_m, v_m);
    end
    tick;
    checks++;
    if (v_m !== 1'b0) begin
      failures++; $display("FAIL basic_latency: valid=%b at edge+2 expected 0", v_m);
    end
    tick;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (v_m !== 1'b1 || od_m !== msb_byte(w, k)) begin
        failures++; $display("FAIL basic_msb[%0d]: got %b/%h expected 1/%h", k, v_m, od_m, msb_byte(w, k));
      end
      checks++;
      if (v_l !== 1'b1 || od_l !== lsb_byte(w, k)) begin
        failures++; $display("FAIL basic_lsb[%0d]: got %b/%h expected 1/%h", k, v_l, od_l, lsb_byte(w, k));
      end
      tick;
    end
    checks++;
    if (v_m !== 1'b0 || v_l !== 1'b0 || b_m !== 1'b0) begin
      failures++; $display("FAIL basic_end: got valid=%b%b busy=%b expected 0", v_m, v_l, b_m);
    end
  endtask
  task automatic test_backpressure;
    sender_ready = 0; data = 32'hA1B2C3D4; start = 1;
    tick; start = 0;
    for (int i = 0; i < 10 && !v_m; i++) tick;
    checks++;
    if (v_m !== 1'b1) begin
      failures++; $display("FAIL bp_timeout: valid=%b expected 1", v_m);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (v_m !== 1'b1 || od_m !== 8'hA1) begin
        failures++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/a1", i, v_m, od_m);
      end
      tick;
    end
    sender_ready = 1;
    tick;
    checks++;
    if (v_m !== 1'b1 || od_m !== 8'hB2) begin
      failures++; $display("FAIL bp_next: got %b/%h expected 1/b2", v_m, od_m);
    end
    for (int i = 0; i < 10 && v_m; i++) tick;
    checks++;
    if (v_m !== 1'b0 || b_m !== 1'b0) begin
      failures++; $display("FAIL bp_drain: got valid=%b busy=%b expected 0/0", v_m, b_m);
    end
  endtask
  task automatic test_overflow;
    logic [31:0] words [5];
    int j = 0;
    sender_ready = 0;
    for (int w = 0; w < 5; w++) begin
      words[w] = 32'h1020_3040 + 32'h0101_0101 * w;
      data = words[w]; start = 1;
      tick; start = 0;
      tick;
    end
    checks++;
    if (c_m !== 3'd4 || f_m !== 1'b1 || o_m !== 1'b0 || b_m !== 1'b1) begin
      failures++; $display("FAIL ovf_full: got count=%0d full=%b ovf=%b busy=%b expected 4/1/0/1", c_m, f_m, o_m, b_m);
    end
    data = 32'hDEAD_BEEF; start = 1;
    tick; start = 0;
    checks++;
    if (o_m !== 1'b1 || c_m !== 3'd4) begin
      failures++; $display("FAIL ovf_flag: got ovf=%b count=%0d expected 1/4", o_m, c_m);
    end
    sender_ready = 1;
    for (int i = 0; i < 80 && j < 20; i++) begin
      if (v_m) begin
        checks++;
        if (od_m !== msb_byte(words[j / 4], j % 4)) begin
          failures++; $display("FAIL ovf_byte[%0d]: got %h expected %h", j, od_m, msb_byte(words[j / 4], j % 4));
        end
        j++;
      end
      tick;
    end
    checks++;
    if (j != 20) begin
      failures++; $display("FAIL ovf_count: got %0d bytes expected 20", j);
    end
    repeat (5) tick;
    checks++;
    if (v_m !== 1'b0 || b_m !== 1'b0 || o_m !== 1'b1) begin
      failures++; $display("FAIL ovf_end: got valid=%b busy=%b ovf=%b expected 0/0/1", v_m, b_m, o_m);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] w0 = 32'h1122_3344, w1 = 32'h5566_7788;
    sender_ready = 0; data = w0; start = 1;
    tick; start = 0;
    tick; data = w1; start = 1;
    tick; start = 0;
    repeat (4) tick;
    sender_ready = 1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (v_m !== 1'b1 || od_m !== msb_byte(k < 4 ? w0 : w1, k % 4)) begin
        failures++; $display("FAIL b2b[%0d]: got %b/%h expected 1/%h", k, v_m, od_m, msb_byte(k < 4 ? w0 : w1, k % 4));
      end
      tick;
    end
    checks++;
    if (v_m !== 1'b0) begin
      failures++; $display("FAIL b2b_end: valid=%b expected 0", v_m);
    end
  endtask
  task automatic test_reset_midword;
    logic seen = 0;
    sender_ready = 1; data = 32'hCAFE_F00D; start = 1;
    tick; start = 0;
    tick; data = 32'h1234_5678; start = 1;
    tick; start = 0;
    tick;
    checks++;
    if (v_m !== 1'b1 || od_m !== 8'hFE) begin
      failures++; $display("FAIL mid_second: got %b/%h expected 1/fe", v_m, od_m);
    end
    reset = 0;
    tick;
    checks++;
    if ({od_m, v_m, f_m, c_m, b_m, o_m} !== '0) begin
      failures++; $display("FAIL mid_reset: got %h expected 0", {od_m, v_m, f_m, c_m, b_m, o_m});
    end
    reset = 1;
    for (int i = 0; i < 12; i++) begin
      seen = seen | v_m | b_m;
      tick;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL mid_residual: got activity=%b expected 0", seen);
    end
    reset = 0; data = 32'h9ABC_DEF0; start = 1;
    tick; reset = 1;
    tick; start = 0;
    checks++;
    if (c_m !== 3'd1) begin
      failures++; $display("FAIL start_after_reset: got count=%0d expected 1", c_m);
    end
    for (int i = 0; i < 10 && !v_m; i++) tick;
    checks++;
    if (v_m !== 1'b1 || od_m !== 8'h9A) begin
      failures++; $display("FAIL start_after_reset_byte: got %b/%h expected 1/9a", v_m, od_m);
    end
    for (int i = 0; i < 10 && v_m; i++) tick;
  endtask
  task automatic test_random;
    logic [7:0] qm[$], ql[$], q1[$];
    logic [7:0] hold_d = 0;
    logic stall = 0;
    logic [31:0] w;
    reset = 0; start = 0; sender_ready = 0;
    tick; reset = 1;
    for (int c = 0; c < 800; c++) begin
      if (stall) begin
        checks++;
        if (v_m !== 1'b1 || od_m !== hold_d) begin
          failures++; $display("FAIL rnd_stable@%0d: got %b/%h expected 1/%h", c, v_m, od_m, hold_d);
        end
      end
      sender_ready = c >= 600 ? 1'b1 : ($urandom % 4) != 0;
      if (start) start = 0;
      else if (c < 600 && ($urandom % 3) == 0 && (qm.size() + 3) / 4 < 4) begin
        w = $urandom; data = w; start = 1;
        for (int k = 0; k < 4; k++) begin
          qm.push_back(msb_byte(w, k));
          ql.push_back(lsb_byte(w, k));
        end
        q1.push_back(w[7:0]);
      end
      if (v_m && sender_ready) begin
        checks++;
        if (qm.size() == 0 || od_m !== qm[0]) begin
          failures++; $display("FAIL rnd_msb@%0d: got %h expected %h", c, od_m, qm.size() ? qm[0] : 8'hxx);
        end
        if (qm.size() != 0) void'(qm.pop_front());
      end
      if (v_l && sender_ready) begin
        checks++;
        if (ql.size() == 0 || od_l !== ql[0]) begin
          failures++; $display("FAIL rnd_lsb@%0d: got %h expected %h", c, od_l, ql.size() ? ql[0] : 8'hxx);
        end
        if (ql.size() != 0) void'(ql.pop_front());
      end
      if (v_1 && sender_ready) begin
        checks++;
        if (q1.size() == 0 || od_1 !== q1[0]) begin
          failures++; $display("FAIL rnd_w1@%0d: got %h expected %h", c, od_1, q1.size() ? q1[0] : 8'hxx);
        end
        if (q1.size() != 0) void'(q1.pop_front());
      end
      stall = v_m && !sender_ready;
      hold_d = od_m;
      tick;
    end
    checks++;
    if (qm.size() + ql.size() + q1.size() != 0 || {v_m, v_l, v_1, o_m, o_l, o_1} !== '0) begin
      failures++; $display("FAIL rnd_end: got left=%0d/%0d/%0d flags=%b expected 0", qm.size(), ql.size(), q1.size(), {v_m, v_l, v_1, o_m, o_l, o_1});
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_back_to_back;
    test_reset_midword;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
